traffic_ctrl_n: RTL and testbench
=================================

# traffic_ctrl_n

Parametrised, demand-actuated traffic-light controller: the next-generation member of our sequential controller benchmark family, generalised from a fixed two-road intersection to `NUM_WAYS` approaches. It adds programmable phase timing, latched per-way vehicle requests with round-robin service, and a flashing-red fail-safe mode. The block is a standalone sequential benchmark circuit: one clock domain, with no input-to-output combinational paths.

## Interface

- `NUM_WAYS`, default 4: number of approaches, 2..8.
- `TIMER_W`, default 5: phase-timer width in bits.
- `GREEN_MIN`, default 4: minimum green length in cycles, ≥1.
- `GREEN_MAX`, default 10: maximum green length in cycles. Requires GREEN_MIN ≤ GREEN_MAX ≤ 2^TIMER_W−1.
- `YELLOW_T`, default 2: yellow length in cycles, ≥1.
- `ALLRED_T`, default 1: all-red clearance length in cycles, ≥1.
- `FLASH_HALF`, default 3: cycles per half-period of the flash, ≥1.
- `CK` in 1: clock. All state changes on the rising edge.
- `RSTN` in 1: reset, asynchronous assert, active-low.
- `EN` in 1: advance enable. When 0, all state is frozen.
- `SENSOR` in NUM_WAYS: vehicle-present pulse or level, one bit per way.
- `FLASH_REQ` in 1: request for flashing-red mode.
- `GREEN` out NUM_WAYS: green lamp, one-hot or zero.
- `YELLOW` out NUM_WAYS: yellow lamp, one-hot or zero.
- `RED` out NUM_WAYS: red lamp.
- `ACTIVE` out $clog2(NUM_WAYS): index of the current or last-served way.
- `REQ` out NUM_WAYS: latched pending requests.
- `PHASE` out 2: encoded phase. ALLRED=0, GREEN=1, YELLOW=2, FLASH=3.

## Operation

**Registers**

- `phase`, `cur`, `timer`, `req` and `flash_bit`. All outputs are decoded from these registers only.

**Reset** (RSTN=0, asynchronous)

- phase=ALLRED, cur=NUM_WAYS−1, timer=0, req=0, flash_bit=0.
- Outputs: GREEN=0, YELLOW=0, RED=all ones, ACTIVE=NUM_WAYS−1, REQ=0, PHASE=0.

**Enable**

- EN=0: nothing changes, including request latching.

**Timer**

- Increments every enabled cycle and saturates at 2^TIMER_W−1.
- Cleared to 0 on every phase change.

**Requests**

- `req[i]` is set when SENSOR[i]=1.
- `req[i]` is cleared on the cycle way i enters GREEN. The clear wins over a same-cycle SENSOR[i].
- Define `other = |(req & ~(1<<cur))`.

**ALLRED** (all RED=1)

- When timer ≥ ALLRED_T−1:
  - If FLASH_REQ=1: go to FLASH.
  - Else if req≠0: pick the first set bit searching cur+1, cur+2, … (mod NUM_WAYS), with cur itself last. Load cur with it and go to GREEN.
  - Else: rest in ALLRED. The timer saturates.

**GREEN** (way cur: GREEN=1, RED=0; all other ways RED=1)

- Go to YELLOW when any of the following holds:
  - timer ≥ GREEN_MIN−1 and (other or FLASH_REQ);
  - timer = GREEN_MAX−1.

**YELLOW** (way cur: YELLOW=1, RED=0)

- Go to ALLRED when timer = YELLOW_T−1.

**FLASH** (GREEN=YELLOW=0; RED = flash_bit replicated to all ways)

- flash_bit toggles when timer = FLASH_HALF−1, and the timer restarts at 0 on that cycle.
- Entry sets flash_bit=1.
- When FLASH_REQ=0: go to ALLRED with timer=0. cur is unchanged.
- Requests keep latching while in FLASH.

**Invariant**

- At most one way is non-red in GREEN or YELLOW.

## Timing

- **Phase lengths:** a phase with length L occupies exactly L enabled cycles. Timer reads 0 in the first cycle of a phase and L−1 in the last.
- **Output latency:** outputs change on the clock edge that updates the phase.
- **Input latency:** SENSOR affects REQ one edge later. It can trigger a GREEN→YELLOW transition at the earliest on the edge after that.
- **FLASH_REQ:** sampled each edge with no latch.
  - If deasserted before the ALLRED exit, normal service resumes.
  - Asserted mid-GREEN before GREEN_MIN: green still lasts GREEN_MIN, then YELLOW_T cycles.
- **Mid-operation reset:** returns all registers to reset values immediately, regardless of CK.
- **Wrap-around:** the round-robin search wraps from NUM_WAYS−1 to 0.

## Test plan

Parameters for all scenarios: NUM_WAYS=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1, FLASH_HALF=3.

1. **Single request.** Reset, then pulse SENSOR=0b0100 for 1 cycle. Required: REQ=0b0100; ALLRED exit to GREEN on way 2; REQ cleared; green lasts 10 cycles (no other request); YELLOW 2 cycles; ALLRED rest.
2. **Early yield.** During way-2 green at timer=1, pulse SENSOR=0b0001. Required: green ends after exactly 4 cycles, YELLOW 2, ALLRED 1, then GREEN way 0 (wrap from 2→3→0, way 3 idle).
3. **Round-robin fairness.** Hold SENSOR=0b1111. Required: ACTIVE sequence 0,1,2,3,0,… with each green exactly 4 cycles and never two non-red ways.
4. **Flash mode.** Assert FLASH_REQ during green at timer=0. Required: green 4 cycles, yellow 2, all-red 1, then FLASH with RED toggling 1111/0000 every 3 cycles. Deassert FLASH_REQ: ALLRED next edge, then service pending requests.
5. **Freeze.** Drop EN for 5 cycles mid-yellow. Required: all outputs and timer unchanged. SENSOR pulses during the freeze are not latched.
6. **Asynchronous reset.** Assert RSTN=0 between edges during GREEN. Required: RED=1111, GREEN=0, REQ=0, ACTIVE=3 immediately.

Source files
------------

// File: rtl/traffic_ctrl_n.sv
// Demand-actuated traffic-light controller for NUM_WAYS approaches with
// latched requests, round-robin service and a flashing-red fail-safe mode.
module traffic_ctrl_n #(
    parameter int NUM_WAYS   = 4,
    parameter int TIMER_W    = 5,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int FLASH_HALF = 3
) (
    input  logic                        CK,
    input  logic                        RSTN,
    input  logic                        EN,
    input  logic [NUM_WAYS-1:0]         SENSOR,
    input  logic                        FLASH_REQ,
    output logic [NUM_WAYS-1:0]         GREEN,
    output logic [NUM_WAYS-1:0]         YELLOW,
    output logic [NUM_WAYS-1:0]         RED,
    output logic [$clog2(NUM_WAYS)-1:0] ACTIVE,
    output logic [NUM_WAYS-1:0]         REQ,
    output logic [1:0]                  PHASE
);

    localparam int AW = $clog2(NUM_WAYS);

    localparam logic [TIMER_W-1:0] T_AR   = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] T_GMIN = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] T_GMAX = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] T_Y    = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] T_FH   = TIMER_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    phase_t                phase;
    logic [AW-1:0]         cur;
    logic [TIMER_W-1:0]    timer;
    logic [NUM_WAYS-1:0]   req;
    logic                  flash_bit;

    logic [TIMER_W-1:0]    timer_inc;
    logic [NUM_WAYS-1:0]   cur_oh;
    logic [NUM_WAYS-1:0]   pick_oh;
    logic [AW-1:0]         pick;
    logic                  other;
    int                    idx;

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    assign cur_oh    = NUM_WAYS'(1) << cur;
    assign pick_oh   = NUM_WAYS'(1) << pick;
    assign other     = |(req & ~cur_oh);

    // Scan from farthest to nearest so the nearest pending way after cur wins.
    always_comb begin
        pick = cur;
        idx  = 0;
        for (int k = NUM_WAYS; k >= 1; k--) begin
            idx = (int'(cur) + k) % NUM_WAYS;
            if (req[idx]) pick = AW'(idx);
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            phase     <= PH_ALLRED;
            cur       <= AW'(NUM_WAYS - 1);
            timer     <= '0;
            req       <= '0;
            flash_bit <= 1'b0;
        end else if (EN) begin
            req   <= req | SENSOR;
            timer <= timer_inc;
            unique case (phase)
                PH_ALLRED: begin
                    if (timer >= T_AR) begin
                        if (FLASH_REQ) begin
                            phase     <= PH_FLASH;
                            timer     <= '0;
                            flash_bit <= 1'b1;
                        end else if (|req) begin
                            phase <= PH_GREEN;
                            cur   <= pick;
                            timer <= '0;
                            req   <= (req | SENSOR) & ~pick_oh;
                        end
                    end
                end
                PH_GREEN: begin
                    if ((timer >= T_GMIN && (other || FLASH_REQ)) ||
                        timer == T_GMAX) begin
                        phase <= PH_YELLOW;
                        timer <= '0;
                    end
                end
                PH_YELLOW: begin
                    if (timer == T_Y) begin
                        phase <= PH_ALLRED;
                        timer <= '0;
                    end
                end
                PH_FLASH: begin
                    if (!FLASH_REQ) begin
                        phase <= PH_ALLRED;
                        timer <= '0;
                    end else if (timer == T_FH) begin
                        flash_bit <= ~flash_bit;
                        timer     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        GREEN  = '0;
        YELLOW = '0;
        RED    = '1;
        unique case (phase)
            PH_GREEN: begin
                GREEN = cur_oh;
                RED   = ~cur_oh;
            end
            PH_YELLOW: begin
                YELLOW = cur_oh;
                RED    = ~cur_oh;
            end
            PH_FLASH:  RED = {NUM_WAYS{flash_bit}};
            default: ;
        endcase
    end

    assign ACTIVE = cur;
    assign REQ    = req;
    assign PHASE  = phase;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Self-checking bench for traffic_ctrl_n: directed scenarios plus
// randomized traffic compared against a rule-level reference model.
module tb_traffic_ctrl_n;

    localparam int N    = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int FH   = 3;

    logic       CK = 1'b0;
    logic       RSTN = 1'b0;
    logic       EN = 1'b0;
    logic [3:0] SENSOR = 4'b0;
    logic       FLASH_REQ = 1'b0;
    logic [3:0] GREEN, YELLOW, RED, REQ;
    logic [1:0] ACTIVE, PHASE;

    traffic_ctrl_n #(
        .NUM_WAYS(N), .TIMER_W(5), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(ART), .FLASH_HALF(FH)
    ) dut (
        .CK(CK), .RSTN(RSTN), .EN(EN), .SENSOR(SENSOR),
        .FLASH_REQ(FLASH_REQ), .GREEN(GREEN), .YELLOW(YELLOW),
        .RED(RED), .ACTIVE(ACTIVE), .REQ(REQ), .PHASE(PHASE)
    );

    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    // Reference model: phase id, cycles spent in phase, served way,
    // pending requests, flash lamp level.
    int       mp;
    int       mage;
    int       mway;
    bit [3:0] mpend;
    bit       mflash;

    function automatic void model_reset();
        mp = 0; mage = 0; mway = N - 1; mpend = 4'b0; mflash = 1'b0;
    endfunction

    task automatic model_step(input bit en, input logic [3:0] s, input bit f);
        bit [3:0] np;
        bit       found;
        bit       oth;
        if (!en) return;
        np = mpend | s;
        case (mp)
            0: begin
                if (mage >= ART - 1 && f) begin
                    mp = 3; mage = 0; mflash = 1'b1;
                end else if (mage >= ART - 1 && mpend != 0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && mpend[(mway + k) % N]) begin
                            found = 1'b1;
                            mway  = (mway + k) % N;
                        end
                    end
                    np[mway] = 1'b0;
                    mp = 1; mage = 0;
                end else mage++;
            end
            1: begin
                oth = (mpend & ~(4'b0001 << mway)) != 0;
                if ((mage >= GMIN - 1 && (oth || f)) || mage == GMAX - 1) begin
                    mp = 2; mage = 0;
                end else mage++;
            end
            2: begin
                if (mage == YT - 1) begin mp = 0; mage = 0; end
                else mage++;
            end
            default: begin
                if (!f) begin mp = 0; mage = 0; end
                else if (mage == FH - 1) begin mflash = !mflash; mage = 0; end
                else mage++;
            end
        endcase
        mpend = np;
    endtask

    function automatic logic [19:0] exp_vec();
        logic [3:0] oh, g, y, r;
        oh = 4'b0001 << mway;
        g = 4'b0; y = 4'b0; r = 4'hF;
        case (mp)
            1: begin g = oh; r = ~oh; end
            2: begin y = oh; r = ~oh; end
            3: r = {4{mflash}};
            default: ;
        endcase
        return {g, y, r, 2'(mway), 4'(mpend), 2'(mp)};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {GREEN, YELLOW, RED, ACTIVE, REQ, PHASE};
    endfunction

    task automatic tick(input bit en, input logic [3:0] s, input bit f);
        EN = en; SENSOR = s; FLASH_REQ = f;
        @(posedge CK);
        model_step(en, s, f);
        #1;
    endtask

    task automatic run_phase(input logic [3:0] s, input bit f, output int n);
        logic [1:0] p;
        p = PHASE;
        n = 0;
        while (PHASE === p && n < 64) begin
            tick(1'b1, s, f);
            n++;
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0; EN = 1'b0; SENSOR = 4'b0; FLASH_REQ = 1'b0;
        model_reset();
        @(posedge CK);
        #1 RSTN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({GREEN, YELLOW, RED, ACTIVE, REQ, PHASE} !== {8'h00, 4'hF, 2'd3, 4'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(), {8'h00, 4'hF, 2'd3, 4'h0, 2'd0});
        end
        tick(1'b1, 4'b0, 1'b0);
        checks++;
        if (PHASE !== 2'd0 || RED !== 4'hF) begin
            errors++;
            $display("FAIL idle_rest got=%0d/%b want=0/1111", PHASE, RED);
        end
    endtask

    task automatic test_single_request();
        int n;
        do_reset();
        tick(1'b1, 4'b0100, 1'b0);
        checks++;
        if (REQ !== 4'b0100 || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL single_latch got=%b/%0d want=0100/0", REQ, PHASE);
        end
        tick(1'b1, 4'b0, 1'b0);
        checks++;
        if ({PHASE, ACTIVE, GREEN, RED, REQ} !== {2'd1, 2'd2, 4'b0100, 4'b1011, 4'b0}) begin
            errors++;
            $display("FAIL single_enter got=%h want=%h", {PHASE, ACTIVE, GREEN, RED, REQ},
                     {2'd1, 2'd2, 4'b0100, 4'b1011, 4'b0});
        end
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n !== GMAX) begin
            errors++;
            $display("FAIL single_green_len got=%0d want=%0d", n, GMAX);
        end
        checks++;
        if (PHASE !== 2'd2 || YELLOW !== 4'b0100) begin
            errors++;
            $display("FAIL single_yellow got=%0d/%b want=2/0100", PHASE, YELLOW);
        end
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n !== YT) begin
            errors++;
            $display("FAIL single_yellow_len got=%0d want=%0d", n, YT);
        end
        repeat (3) tick(1'b1, 4'b0, 1'b0);
        checks++;
        if (PHASE !== 2'd0 || RED !== 4'hF || ACTIVE !== 2'd2) begin
            errors++;
            $display("FAIL single_rest got=%0d/%b/%0d want=0/1111/2", PHASE, RED, ACTIVE);
        end
    endtask

    task automatic test_early_yield();
        int n;
        do_reset();
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b0, 1'b0);
        tick(1'b1, 4'b0, 1'b0);
        tick(1'b1, 4'b0001, 1'b0);
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n + 2 !== GMIN) begin
            errors++;
            $display("FAIL yield_green_len got=%0d want=%0d", n + 2, GMIN);
        end
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n !== YT) begin
            errors++;
            $display("FAIL yield_yellow_len got=%0d want=%0d", n, YT);
        end
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n !== ART) begin
            errors++;
            $display("FAIL yield_allred_len got=%0d want=%0d", n, ART);
        end
        checks++;
        if ({PHASE, ACTIVE, GREEN, REQ} !== {2'd1, 2'd0, 4'b0001, 4'b0}) begin
            errors++;
            $display("FAIL yield_wrap got=%h want=%h", {PHASE, ACTIVE, GREEN, REQ},
                     {2'd1, 2'd0, 4'b0001, 4'b0});
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        tick(1'b1, 4'hF, 1'b0);
        tick(1'b1, 4'hF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (PHASE !== 2'd1 || ACTIVE !== 2'(k % N)) begin
                errors++;
                $display("FAIL rr_order got=%0d/%0d want=1/%0d", PHASE, ACTIVE, k % N);
            end
            n = 0;
            while (PHASE === 2'd1 && n < 64) begin
                tick(1'b1, 4'hF, 1'b0);
                n++;
                checks++;
                if ($countones(~RED) > 1) begin
                    errors++;
                    $display("FAIL rr_one_nonred got=%b want=at_most_one_zero", RED);
                end
            end
            checks++;
            if (n !== GMIN) begin
                errors++;
                $display("FAIL rr_green_len got=%0d want=%0d", n, GMIN);
            end
            run_phase(4'hF, 1'b0, n);
            run_phase(4'hF, 1'b0, n);
        end
    endtask

    task automatic test_flash();
        int n;
        do_reset();
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b0, 1'b0);
        run_phase(4'b0, 1'b1, n);
        checks++;
        if (n !== GMIN) begin
            errors++;
            $display("FAIL flash_green_len got=%0d want=%0d", n, GMIN);
        end
        run_phase(4'b0, 1'b1, n);
        checks++;
        if (n !== YT) begin
            errors++;
            $display("FAIL flash_yellow_len got=%0d want=%0d", n, YT);
        end
        run_phase(4'b0, 1'b1, n);
        checks++;
        if (n !== ART) begin
            errors++;
            $display("FAIL flash_allred_len got=%0d want=%0d", n, ART);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (PHASE !== 2'd3 || RED !== (((i / FH) % 2 == 0) ? 4'hF : 4'h0) ||
                GREEN !== 4'b0 || YELLOW !== 4'b0) begin
                errors++;
                $display("FAIL flash_lamps i=%0d got=%0d/%b want=3/%b", i, PHASE, RED,
                         (((i / FH) % 2 == 0) ? 4'hF : 4'h0));
            end
            tick(1'b1, (i == 4) ? 4'b0010 : 4'b0, 1'b1);
        end
        checks++;
        if (REQ !== 4'b0010) begin
            errors++;
            $display("FAIL flash_req_latch got=%b want=0010", REQ);
        end
        tick(1'b1, 4'b0, 1'b0);
        checks++;
        if (PHASE !== 2'd0 || ACTIVE !== 2'd2) begin
            errors++;
            $display("FAIL flash_exit got=%0d/%0d want=0/2", PHASE, ACTIVE);
        end
        tick(1'b1, 4'b0, 1'b0);
        checks++;
        if (PHASE !== 2'd1 || ACTIVE !== 2'd1 || REQ !== 4'b0) begin
            errors++;
            $display("FAIL flash_resume got=%0d/%0d/%b want=1/1/0000", PHASE, ACTIVE, REQ);
        end
    endtask

    task automatic test_freeze();
        int n;
        logic [19:0] want;
        do_reset();
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b0, 1'b0);
        run_phase(4'b0, 1'b0, n);
        want = {4'b0000, 4'b0100, 4'b1011, 2'd2, 4'b0000, 2'd2};
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 4'($urandom_range(1, 15)), 1'b0);
            checks++;
            if (obs_vec() !== want) begin
                errors++;
                $display("FAIL freeze_hold i=%0d got=%h want=%h", i, obs_vec(), want);
            end
        end
        run_phase(4'b0, 1'b0, n);
        checks++;
        if (n !== YT) begin
            errors++;
            $display("FAIL freeze_timer got=%0d want=%0d", n, YT);
        end
        tick(1'b1, 4'b0, 1'b0);
        checks++;
        if (PHASE !== 2'd0 || REQ !== 4'b0) begin
            errors++;
            $display("FAIL freeze_no_latch got=%0d/%b want=0/0000", PHASE, REQ);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b0, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
        checks++;
        if (PHASE !== 2'd1 || REQ !== 4'b0010) begin
            errors++;
            $display("FAIL areset_setup got=%0d/%b want=1/0010", PHASE, REQ);
        end
        #3 RSTN = 1'b0;
        #1;
        checks++;
        if ({GREEN, YELLOW, RED, ACTIVE, REQ, PHASE} !== {8'h00, 4'hF, 2'd3, 4'h0, 2'd0}) begin
            errors++;
            $display("FAIL areset_immediate got=%h want=%h", obs_vec(),
                     {8'h00, 4'hF, 2'd3, 4'h0, 2'd0});
        end
        EN = 1'b0; SENSOR = 4'b0;
        model_reset();
        @(posedge CK);
        #1 RSTN = 1'b1;
    endtask

    task automatic test_random();
        bit         en;
        bit         f;
        logic [3:0] s;
        do_reset();
        f = 1'b0;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 49) == 0) f = !f;
            tick(en, s, f);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_request();
        test_early_yield();
        test_round_robin();
        test_flash();
        test_freeze();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
